shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that turns the single-step shifter into a shift-by-N unit. It accepts an operand, a shift opcode and an amount over a valid/ready handshake, then applies the 1-bit shifter once per clock for N cycles. It presents the result with zero and carry-out flags on a second valid/ready handshake. It sits between the decode/ALU-select logic and the writeback path, wherever the datapath needs shifts larger than one bit.

## Interface
- AMT_W, default 4: width of the shift amount; legal amounts are 0 .. 2^AMT_W-1.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  the block can accept a request; high only in IDLE.
- req_data  input  16  operand.
- req_op  input  2  opcode:
  - 00: pass
  - 01: logical shift left (LSL)
  - 10: logical shift right (LSR)
  - 11: arithmetic shift right (ASR)
- req_amt  input  AMT_W  number of 1-bit steps.
- res_valid  output  1  result present; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- res_data  output  16  shifted result.
- res_zero  output  1  res_data == 0.
- res_carry  output  1  last bit shifted out; 0 if no step was performed.
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, DONE. Internal registers:
  - acc[15:0]
  - op[1:0]
  - cnt[AMT_W-1:0]
  - carry
- The block instantiates the existing shifter with in=acc, shift=op. Its output is the only path by which acc changes during SHIFT.
- IDLE: req_ready=1.
  - On req_valid (the request handshake): acc<=req_data, op<=req_op, cnt<=req_amt, carry<=0.
  - Next state is DONE if req_amt==0 or req_op==00; otherwise SHIFT.
- SHIFT: each cycle acc<=shifter output and cnt<=cnt-1.
  - carry<=acc[15] for LSL; carry<=acc[0] for LSR and ASR.
  - When cnt==1, next state is DONE; otherwise stay in SHIFT.
  - req_valid is ignored in this state.
- DONE: res_valid=1 and res_data=acc. res_zero and res_carry are derived from acc and carry.
  - On res_ready: next state is IDLE. The outputs hold their values until the next request is accepted.
- Op 00 with nonzero amount performs no steps; carry stays 0.
- Amounts ≥16 are legal:
  - LSL and LSR saturate to 0; carry is the last bit shifted out (0 once the operand is exhausted).
  - ASR saturates to all sign bits.
- Reset (rst_n low, at any time including mid-SHIFT or DONE): state=IDLE and acc, op, cnt, carry are all 0. Outputs therefore reset to:
  - req_ready=1
  - res_valid=0
  - res_data=16'h0000
  - res_zero=1
  - res_carry=0
  - busy=0
- An in-flight operation is discarded and produces no result after reset.

## Timing
- Request accepted in cycle k (req_valid & req_ready at the rising edge ending cycle k).
- res_valid is high from cycle k+N+1, where N = amount, or N=0 for op 00.
- Results:
  - amount 0: result in cycle k+1.
  - amount 1: result in cycle k+2.
- res_valid stays high and res_data stable until the res_ready handshake edge. res_valid is low the following cycle.
- req_ready rises in the cycle after the result handshake. There is no request/result overlap, so minimum throughput is one op per N+2 cycles.
- No combinational path from req_* to res_*, or from res_ready to req_ready. All outputs are decoded from registers only.
- Reset assertion takes effect without a clock edge. The first request can be accepted at the first rising edge after rst_n deasserts.

## Test plan
- Reset: hold rst_n=0 → req_ready=1, res_valid=0, res_data=0000, res_zero=1, res_carry=0, busy=0, with no clock edge required.
- LSL: req_data=0001, op=01, amt=4, accepted in cycle k → res_valid first high in cycle k+5, res_data=0010, carry=0, zero=0. Also 8001, amt=1 → 0002, carry=1.
- Right shifts, operand 8000, amt=3:
  - ASR (op=11) → F000, carry=0.
  - LSR (op=10) → 1000, carry=0.
  - LSR of 0001, amt=1 → 0000, zero=1, carry=1.
- Zero-step cases:
  - ABCD, op=01, amt=0 → ABCD in cycle k+1, carry=0.
  - ABCD, op=00, amt=7 → ABCD in cycle k+1, carry=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while driving a new req_valid → res_data and flags stable, req_ready=0, and the new request is not accepted until the cycle after the result handshake.
- Reset mid-operation: 0001, op=01, amt=15; pull rst_n low 6 cycles after acceptance → immediate IDLE, res_valid=0, busy=0. A subsequent request then completes normally with no residue from the aborted one.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shift-by-N controller: iterates a single-step shifter N times over a
// request/result valid-ready pair, reporting zero and last-carry-out flags.

module shifter (
  input  logic [15:0] din,
  input  logic [1:0]  shift,
  output logic [15:0] dout
);
  always_comb begin
    dout = din;
    case (shift)
      2'b01:   dout = {din[14:0], 1'b0};
      2'b10:   dout = {1'b0, din[15:1]};
      2'b11:   dout = {din[15], din[15:1]};
      default: dout = din;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_data,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      acc_reg, acc_next;
  logic [1:0]       op_reg, op_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic [15:0]      step_out;

  shifter u_shifter (
    .din   (acc_reg),
    .shift (op_reg),
    .dout  (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          acc_next   = req_data;
          op_next    = req_op;
          cnt_next   = req_amt;
          carry_next = 1'b0;
          // Pass op or zero amount skips SHIFT entirely, so carry stays 0.
          if (req_amt == '0 || req_op == 2'b00) state_next = DONE;
          else                                  state_next = SHIFT;
        end
      end
      SHIFT: begin
        acc_next   = step_out;
        cnt_next   = cnt_reg - 1'b1;
        carry_next = (op_reg == 2'b01) ? acc_reg[15] : acc_reg[0];
        if (cnt_reg == AMT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode from registers only; acc holds until the next accept.
  assign req_ready = (state_reg == IDLE);
  assign res_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign res_data  = acc_reg;
  assign res_zero  = (acc_reg == 16'h0000);
  assign res_carry = carry_reg;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results, latency,
// backpressure hold and asynchronous reset abort.

module tb_shift_sequencer;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_data;
  logic [1:0]       req_op;
  logic [AMT_W-1:0] req_amt;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic             res_zero;
  logic             res_carry;
  logic             busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  shift_sequencer #(.AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_carry (res_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request and wait (bounded) for the result; checks latency and result.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [1:0] op,
                        input logic [AMT_W-1:0] amt, input logic [15:0] ed,
                        input logic ec, input int elat);
    int n;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = d; req_op = op; req_amt = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n + 1), 32'(elat));
    check({tag, "_data"},  32'(res_data),  32'(ed));
    check({tag, "_zero"},  32'(res_zero),  32'(ed == 16'h0000));
    check({tag, "_carry"}, 32'(res_carry), 32'(ec));
    check({tag, "_busy"},  32'(busy),      32'd1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_after_ready"}, 32'(req_ready), 32'd1);
    $display("op %s: data=%h op=%b amt=%0d -> res=%h carry=%b lat=%0d", tag, d, op, amt,
             res_data, res_carry, n + 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_op = '0; req_amt = '0; res_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'h0);
    check("rst_res_zero",  32'(res_zero),  32'd1);
    check("rst_res_carry", 32'(res_carry), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("lsl4",    16'h0001, 2'b01, 4'd4,  16'h0010, 1'b0, 5);
    run_op("lsl1",    16'h8001, 2'b01, 4'd1,  16'h0002, 1'b1, 2);
    run_op("asr3",    16'h8000, 2'b11, 4'd3,  16'hF000, 1'b0, 4);
    run_op("lsr3",    16'h8000, 2'b10, 4'd3,  16'h1000, 1'b0, 4);
    run_op("lsr1z",   16'h0001, 2'b10, 4'd1,  16'h0000, 1'b1, 2);
    run_op("lsl0",    16'hABCD, 2'b01, 4'd0,  16'hABCD, 1'b0, 1);
    run_op("pass7",   16'hABCD, 2'b00, 4'd7,  16'hABCD, 1'b0, 1);
    run_op("asr15",   16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 16);
    run_op("lsr15",   16'hFFFF, 2'b10, 4'd15, 16'h0001, 1'b1, 16);
    run_op("lsl15",   16'h0001, 2'b01, 4'd15, 16'h8000, 1'b0, 16);

    // Backpressure: result held while a new request waits.
    req_valid = 1'b1; req_data = 16'h00F0; req_op = 2'b10; req_amt = 4'd4;
    @(posedge clk); #1;
    req_data = 16'h0003; req_op = 2'b01; req_amt = 4'd2;
    n = 0;
    while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp_latency", 32'(n + 1), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data",  32'(res_data),  32'h000F);
      check("bp_hold_carry", 32'(res_carry), 32'd0);
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_req_ready",  32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(res_valid), 32'd0);
    check("bp_idle_data",  32'(res_data),  32'h000F);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_new_busy", 32'(busy), 32'd1);
    n = 0;
    while (!res_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp_new_latency", 32'(n + 1), 32'd3);
    check("bp_new_data",    32'(res_data), 32'h000C);
    $display("op bp: 00F0 lsr 4 -> 000F held, then 0003 lsl 2 -> %h", res_data);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset mid-operation aborts without a clock edge.
    req_valid = 1'b1; req_data = 16'h0001; req_op = 2'b01; req_amt = 4'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_res_data",  32'(res_data),  32'h0);
    check("abort_res_carry", 32'(res_carry), 32'd0);
    $display("op abort: reset during lsl 15, res_data=%h busy=%b", res_data, busy);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h0005, 2'b10, 4'd1, 16'h0002, 1'b1, 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
